// File: rtl/wb_pipe_pkg.sv
// ---------------------------------------------------------------------------
// wb_pipe_pkg
// Shared definitions for the writeback pipeline: the NOP register address,
// the zero data word, the writeback entry layout {wd, wreg, wdata} at the
// default widths, and the NOP entry constant that unoccupied slots hold.
// ---------------------------------------------------------------------------
package wb_pipe_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    localparam logic [WB_ADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam logic [WB_DATA_W-1:0] ZERO_WORD    = '0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] wd;
        logic                 wreg;
        logic [WB_DATA_W-1:0] wdata;
    } wb_entry_t;

    localparam wb_entry_t WB_NOP_ENTRY = '{wd: NOP_REG_ADDR, wreg: 1'b0, wdata: ZERO_WORD};

endpackage

// File: rtl/wb_fwd_match.sv
// ---------------------------------------------------------------------------
// wb_fwd_match
// Priority search over DEPTH buffered writeback entries. A slot matches when
// it is occupied (index < count_i), writes a register (wreg_i) and its
// destination equals addr_i. The youngest (highest-index) match wins.
// Register 0 is never reported as a hit.
// Ports:
//   wd_i, wreg_i, wdata_i : per-slot entry fields, slot 0 is the oldest
//   count_i               : number of occupied slots
//   addr_i                : lookup address
//   hit_o, data_o         : match flag and data of the youngest match (0 if none)
// ---------------------------------------------------------------------------
module wb_fwd_match
    import wb_pipe_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic [ADDR_W-1:0] wd_i    [DEPTH],
    input  logic              wreg_i  [DEPTH],
    input  logic [DATA_W-1:0] wdata_i [DEPTH],
    input  logic [CNT_W-1:0]  count_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        hit_o  = 1'b0;
        data_o = DATA_W'(ZERO_WORD);
        if (addr_i != ADDR_W'(NOP_REG_ADDR)) begin
            // Ascending scan so a later (younger) match overrides an older one.
            for (int i = 0; i < DEPTH; i++) begin
                if ((CNT_W'(i) < count_i) && wreg_i[i] && (wd_i[i] == addr_i)) begin
                    hit_o  = 1'b1;
                    data_o = wdata_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/wb_skid_stage.sv
// ---------------------------------------------------------------------------
// wb_skid_stage
// Elastic MEM/WB stage: an in-order shift-register FIFO of DEPTH writeback
// entries with valid/ready on both sides, stall and global-ready gating,
// synchronous flush and forwarding across all buffered entries. slot 0 drives
// the outputs; an empty buffer presents a NOP bubble.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   rdy                   : global ready, low freezes everything except flush
//   stall_sign            : stall vector; [STALL_IDX] upstream, [STALL_IDX+1] downstream
//   flush                 : synchronous clear of all entries
//   in_valid/in_ready     : MEM-side handshake; in_wd/in_wreg/in_wdata entry
//   out_valid/out_ready   : WB-side handshake; out_wd/out_wreg/out_wdata head entry
//   count                 : registered occupancy
//   fwd_addr/fwd_hit/fwd_data : combinational forwarding lookup
// ---------------------------------------------------------------------------
module wb_skid_stage
    import wb_pipe_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 2,
    parameter int STALL_W   = 6,
    parameter int STALL_IDX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic [STALL_W-1:0]           stall_sign,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_wd,
    input  logic                         in_wreg,
    input  logic [DATA_W-1:0]            in_wdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_W-1:0]            out_wd,
    output logic                         out_wreg,
    output logic [DATA_W-1:0]            out_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic [ADDR_W-1:0]            fwd_addr,
    output logic                         fwd_hit,
    output logic [DATA_W-1:0]            fwd_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    localparam entry_t NOP_ENTRY = '{wd:    ADDR_W'(NOP_REG_ADDR),
                                     wreg:  1'b0,
                                     wdata: DATA_W'(ZERO_WORD)};

    entry_t            slot_q [DEPTH];
    entry_t            slot_d [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  widx;
    entry_t            in_entry;
    logic              stall_up;
    logic              stall_dn;
    logic              push;
    logic              pop;

    // Only two bits of the stall vector belong to this stage.
    logic              unused_stall;
    assign unused_stall = ^stall_sign;

    assign stall_up  = stall_sign[STALL_IDX];
    assign stall_dn  = stall_sign[STALL_IDX+1];

    // in_ready deliberately ignores out_ready so no combinational path runs
    // from the WB side back to MEM; the cost is no push-through at full.
    assign in_ready  = rdy & ~stall_up & (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & rdy & ~stall_dn;

    assign in_entry  = '{wd: in_wd, wreg: in_wreg, wdata: in_wdata};

    // With a simultaneous pop the queue shifts first, so the new entry lands
    // one slot lower. pop implies count_q >= 1, so this never underflows.
    assign widx = pop ? (count_q - CNT_W'(1)) : count_q;

    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) slot_d[i] = NOP_ENTRY;
            count_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) slot_d[i] = slot_q[i+1];
                slot_d[DEPTH-1] = NOP_ENTRY;
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == widx) slot_d[i] = in_entry;
                end
            end
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= NOP_ENTRY;
            count_q <= '0;
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
        end
    end

    assign out_wd    = slot_q[0].wd;
    assign out_wreg  = slot_q[0].wreg;
    assign out_wdata = slot_q[0].wdata;
    assign count     = count_q;

    logic [ADDR_W-1:0] f_wd    [DEPTH];
    logic              f_wreg  [DEPTH];
    logic [DATA_W-1:0] f_wdata [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            f_wd[i]    = slot_q[i].wd;
            f_wreg[i]  = slot_q[i].wreg;
            f_wdata[i] = slot_q[i].wdata;
        end
    end

    wb_fwd_match #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fwd (
        .wd_i    (f_wd),
        .wreg_i  (f_wreg),
        .wdata_i (f_wdata),
        .count_i (count_q),
        .addr_i  (fwd_addr),
        .hit_o   (fwd_hit),
        .data_o  (fwd_data)
    );

endmodule

// File: tb/tb_wb_skid_stage.sv
module tb_wb_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [5:0]  stall_sign;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_wd;
    logic        in_wreg;
    logic [31:0] in_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_wd;
    logic        out_wreg;
    logic [31:0] out_wdata;
    logic [1:0]  count;
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    int vectors = 0;
    int miscompares = 0;

    wb_skid_stage #(
        .ADDR_W(5), .DATA_W(32), .DEPTH(2), .STALL_W(6), .STALL_IDX(4)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall_sign(stall_sign), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_wd(in_wd), .in_wreg(in_wreg),
        .in_wdata(in_wdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata), .count(count),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [4:0] wd, input logic wr, input logic [31:0] d);
        in_valid = v;
        in_wd    = wd;
        in_wreg  = wr;
        in_wdata = d;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; stall_sign = '0; flush = 1'b0;
        out_ready = 1'b0; fwd_addr = '0;
        drive_in(1'b0, 5'd0, 1'b0, 32'h0);
        #12;
        rst = 1'b0;
        #1;
        chk("rst_count",     32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);

        // Single push into an empty buffer.
        drive_in(1'b1, 5'd5, 1'b1, 32'hDEADBEEF);
        tick();
        drive_in(1'b0, 5'd0, 1'b0, 32'h0);
        chk("push_out_valid", 32'(out_valid), 32'd1);
        chk("push_out_wd",    32'(out_wd), 32'd5);
        chk("push_out_wdata", out_wdata, 32'hDEADBEEF);
        chk("push_count",     32'(count), 32'd1);
        fwd_addr = 5'd5;
        #1;
        chk("push_fwd_hit",  32'(fwd_hit), 32'd1);
        chk("push_fwd_data", fwd_data, 32'hDEADBEEF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_count",     32'(count), 32'd0);
        chk("pop_out_wd",    32'(out_wd), 32'd0);
        chk("pop_fwd_hit",   32'(fwd_hit), 32'd0);

        // Fill to full, overflow push ignored, then drain.
        drive_in(1'b1, 5'd1, 1'b1, 32'h11);
        tick();
        drive_in(1'b1, 5'd2, 1'b1, 32'h22);
        tick();
        chk("full_count",    32'(count), 32'd2);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drive_in(1'b1, 5'd3, 1'b1, 32'h33);
        tick();
        drive_in(1'b0, 5'd0, 1'b0, 32'h0);
        chk("ovf_count", 32'(count), 32'd2);
        chk("ovf_head",  out_wdata, 32'h11);
        fwd_addr = 5'd3;
        #1;
        chk("ovf_fwd_hit", 32'(fwd_hit), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("drain1_data",     out_wdata, 32'h22);
        chk("drain1_count",    32'(count), 32'd1);
        chk("drain1_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("drain2_valid", 32'(out_valid), 32'd0);
        chk("drain2_data",  out_wdata, 32'h0);
        chk("drain2_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Upstream stall with empty buffer: bubble, no acceptance.
        stall_sign = 6'b010000;
        #1;
        chk("stup_in_ready", 32'(in_ready), 32'd0);
        drive_in(1'b1, 5'd6, 1'b1, 32'h66);
        tick();
        drive_in(1'b0, 5'd0, 1'b0, 32'h0);
        chk("stup_out_valid", 32'(out_valid), 32'd0);
        chk("stup_out_wdata", out_wdata, 32'h0);
        chk("stup_count",     32'(count), 32'd0);
        stall_sign = '0;
        drive_in(1'b1, 5'd7, 1'b1, 32'h77);
        tick();
        drive_in(1'b0, 5'd0, 1'b0, 32'h0);
        // Downstream stall holds the entry despite out_ready.
        stall_sign = 6'b100000;
        out_ready  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stdn_count", 32'(count), 32'd1);
            chk("stdn_data",  out_wdata, 32'h77);
        end
        stall_sign = '0;
        rdy = 1'b0;
        #1;
        chk("rdy0_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("rdy0_count", 32'(count), 32'd1);
        chk("rdy0_data",  out_wdata, 32'h77);
        rdy = 1'b1;
        tick();
        chk("rdy1_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Forwarding: youngest match wins, address 0 never hits.
        drive_in(1'b1, 5'd3, 1'b1, 32'hA);
        tick();
        drive_in(1'b1, 5'd3, 1'b1, 32'hB);
        tick();
        drive_in(1'b0, 5'd0, 1'b0, 32'h0);
        fwd_addr = 5'd3;
        #1;
        chk("fwd_young_hit",  32'(fwd_hit), 32'd1);
        chk("fwd_young_data", fwd_data, 32'hB);
        fwd_addr = 5'd0;
        #1;
        chk("fwd_zero_hit",  32'(fwd_hit), 32'd0);
        chk("fwd_zero_data", fwd_data, 32'h0);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        drive_in(1'b1, 5'd3, 1'b0, 32'hC);
        tick();
        drive_in(1'b1, 5'd4, 1'b1, 32'h44);
        tick();
        drive_in(1'b0, 5'd0, 1'b0, 32'h0);
        fwd_addr = 5'd3;
        #1;
        chk("fwd_nowreg_hit", 32'(fwd_hit), 32'd0);
        fwd_addr = 5'd4;
        #1;
        chk("fwd_old_hit",  32'(fwd_hit), 32'd1);
        chk("fwd_old_data", fwd_data, 32'h44);

        // Flush beats push, pop and rdy low.
        chk("pre_flush_count", 32'(count), 32'd2);
        flush = 1'b1; rdy = 1'b0; out_ready = 1'b1;
        drive_in(1'b1, 5'd5, 1'b1, 32'h55);
        tick();
        flush = 1'b0; rdy = 1'b1; out_ready = 1'b0;
        drive_in(1'b0, 5'd0, 1'b0, 32'h0);
        fwd_addr = 5'd5;
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_wd",    32'(out_wd), 32'd0);
        chk("flush_fwd",   32'(fwd_hit), 32'd0);

        // Asynchronous reset with two entries buffered, mid-cycle.
        drive_in(1'b1, 5'd9, 1'b1, 32'h99);
        tick();
        drive_in(1'b1, 5'd10, 1'b1, 32'hAA);
        tick();
        drive_in(1'b0, 5'd0, 1'b0, 32'h0);
        fwd_addr = 5'd10;
        #1;
        chk("arst_pre_count", 32'(count), 32'd2);
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_wd",    32'(out_wd), 32'd0);
        chk("arst_wreg",  32'(out_wreg), 32'd0);
        chk("arst_wdata", out_wdata, 32'h0);
        chk("arst_fhit",  32'(fwd_hit), 32'd0);
        chk("arst_fdata", fwd_data, 32'h0);
        rst = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_skid_stage.md
# wb_skid_stage

Parametrised, elastic successor to the single-slot MEM/WB pipeline register. It holds up to `DEPTH` writeback entries `{wd, wreg, wdata}` in order, with a valid/ready handshake on both sides, global `stall_sign` and `rdy` gating, synchronous flush, and a forwarding lookup across all buffered entries. It sits between the MEM stage and the register-file write port. When the buffer is empty it presents a NOP bubble.

## Interface
Parameters:
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: write data width.
- `DEPTH`, default 2: buffered entries, legal range 1..8.
- `STALL_W`, default 6: width of `stall_sign`.
- `STALL_IDX`, default 4: upstream stall bit. Bit `STALL_IDX+1` is the downstream stall bit.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rdy`  in  1  global ready. Low freezes the block.
- `stall_sign`  in  STALL_W  pipeline stall vector.
- `flush`  in  1  synchronous clear of all entries.
- `in_valid`  in  1  MEM entry valid.
- `in_ready`  out  1  block can accept an entry.
- `in_wd`  in  ADDR_W  destination register.
- `in_wreg`  in  1  write enable.
- `in_wdata`  in  DATA_W  write data.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  WB consumes the head.
- `out_wd`, `out_wreg`, `out_wdata`  out  ADDR_W / 1 / DATA_W  head entry, registered.
- `count`  out  $clog2(DEPTH+1)  occupancy, registered.
- `fwd_addr`  in  ADDR_W  forwarding lookup address.
- `fwd_hit`  out  1  a buffered entry writes `fwd_addr`.
- `fwd_data`  out  DATA_W  data of the youngest matching entry.

## Operation
Storage and control signals:
- Storage is a shift-register FIFO, `slot[0..DEPTH-1]`. `slot[0]` drives the `out_*` ports directly.
- Every unoccupied slot holds NOP: wd=0, wreg=0, wdata=0.
- `stall_up` = `stall_sign[STALL_IDX]`.
- `stall_dn` = `stall_sign[STALL_IDX+1]`.
- `in_ready` = `rdy & !stall_up & (count < DEPTH)`. It depends only on registers and global inputs, never on `out_ready`.
- `push` = `in_valid & in_ready`.
- `pop` = `out_valid & out_ready & rdy & !stall_dn`.
- `out_valid` = `count != 0`.

Per-edge behaviour, in priority order:
1. `flush`: all slots become NOP and `count` becomes 0. Any simultaneous push or pop is discarded. Flush works even when `rdy` is low.
2. `rdy` low: hold all state.
3. Pop only: `slot[i] <= slot[i+1]`, the top slot becomes NOP, and `count` decrements.
4. Push only: `slot[count]` takes the input entry and `count` increments.
5. Push and pop together: shift down, then write the input to `slot[count-1]`. `count` is unchanged. This is legal at full only if `in_ready` was high, which it is not, so it never occurs at full.

Bubble rule:
- `stall_up & !stall_dn` with an empty buffer: the output stays NOP and `out_valid` is 0.
- `stall_up & stall_dn`: the contents hold.

Forwarding:
- Combinational.
- A slot matches when it is occupied (i < count), has `wreg` = 1, and its `wd` equals `fwd_addr`.
- A `fwd_addr` of 0 never hits.
- `fwd_data` comes from the highest-index (youngest) matching slot, and is 0 when there is no hit.

## Timing
- Reset, asynchronous: every slot becomes NOP and `count` = 0. The outputs are then `out_valid`=0, `out_wd`=0, `out_wreg`=0, `out_wdata`=0, `fwd_hit`=0 and `fwd_data`=0. `in_ready` then follows `rdy & !stall_up`.
- Reset in the middle of a burst discards all entries immediately, with no clock required.
- Latency: an entry pushed at edge N appears on `out_*` after edge N, when the buffer was empty. It is delayed by the occupancy otherwise.
- Throughput: with `DEPTH` ≥ 2 and continuous push plus pop, the block sustains one entry per cycle. With `DEPTH` = 1, throughput is at most one entry every 2 cycles.
- Full: `in_ready` drops in the same cycle that `count` reaches `DEPTH`. It rises the cycle after a pop registers.
- `count` never exceeds `DEPTH` and never underflows, because pop requires `out_valid`.
- Forwarding reflects the current registered contents in the same cycle. Entries being pushed in the current cycle are not visible to the lookup.

## Structure
- Shared package `wb_pipe_pkg` holds:
  - `NOP_REG_ADDR` and `ZERO_WORD`;
  - the typedef `wb_entry_t` = `{wd, wreg, wdata}`, parametrised through the package defaults;
  - the constant `WB_NOP_ENTRY`.
- Sub-module `wb_fwd_match` is a parametrised priority search over `DEPTH` entries plus `count`, producing `hit` and `data`. It is instantiated once.

## Test plan
- **Reset:** assert `rst` mid-cycle with 2 entries buffered → all outputs 0 and `count`=0 with no clock edge. Deassert with `rdy`=1 → `in_ready`=1.
- **Single push:** push {wd=5, wreg=1, wdata=0xDEADBEEF} into an empty buffer with `out_ready`=0 → after 1 edge, `out_valid`=1, `out_wd`=5 and `count`=1.
- **Fill and full, `DEPTH`=2:** push 0x11 then 0x22 with `out_ready`=0 → `count`=2 and `in_ready`=0. A third push of 0x33 is ignored. Raise `out_ready` → the outputs show 0x11, then 0x22, then NOP with `count`=0.
- **Stall semantics:** `stall_sign[4]`=1 and `[5]`=0 with an empty buffer → `in_ready`=0 and the output stays NOP. Set `[5]`=1 with 1 entry buffered and `out_ready`=1 → the entry holds for 3 cycles. Set `rdy`=0 → nothing moves.
- **Forwarding:** buffer {wd=3, 0xA} then {wd=3, 0xB}. Set `fwd_addr`=3 → `fwd_hit`=1 and `fwd_data`=0xB. `fwd_addr`=0 → no hit. An entry with wd=3 and wreg=0 → no hit.
- **Flush collision:** with `count`=2, raise `flush` together with push, pop and `rdy`=0 → after the edge `count`=0, the output is NOP and the pushed entry is lost.
